// File: rtl/cp0_fwd_tracker.sv
// CP0 forwarding scoreboard: DEPTH-entry shift register of in-flight MTC0/SYSCALL ops.
// Optional statistics counters are enabled with the CP0_FWD_STATS_EN macro.
module cp0_fwd_tracker #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CS_W   = 5,
  parameter int SEL_W  = 3,
  parameter int EPC_CS = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_hold,
  input  logic                       id_stall,
  input  logic [DEPTH-1:0]           flush_mask,
  input  logic                       id_valid,
  input  logic [2:0]                 id_cp0_op,
  input  logic [CS_W-1:0]            id_cs,
  input  logic [SEL_W-1:0]           id_sel,
  input  logic [DATA_W-1:0]          id_wdata,
  input  logic [DATA_W-1:0]          rf_rdata,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH+1)-1:0] fwd_src,
  output logic                       cp0_stall,
  output logic                       sys_inflight
`ifdef CP0_FWD_STATS_EN
  ,
  output logic [31:0]                stat_fwd_cnt,
  output logic [31:0]                stat_stall_cnt
`endif
);

  localparam int unsigned SRC_W = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_MFC0 = 3'b001,
    OP_MTC0 = 3'b010,
    OP_SYS  = 3'b011,
    OP_ERET = 3'b100
  } cp0_op_e;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  sys_q,   sys_d;
  logic [CS_W-1:0]   cs_q   [DEPTH];
  logic [CS_W-1:0]   cs_d   [DEPTH];
  logic [SEL_W-1:0]  sel_q  [DEPTH];
  logic [SEL_W-1:0]  sel_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic is_mfc0, is_mtc0, is_sys, is_eret, lookup_en, load;
  logic [CS_W-1:0]  lk_cs;
  logic [SEL_W-1:0] lk_sel;

  assign is_mfc0 = (id_cp0_op == OP_MFC0);
  assign is_mtc0 = (id_cp0_op == OP_MTC0);
  assign is_sys  = (id_cp0_op == OP_SYS);
  assign is_eret = (id_cp0_op == OP_ERET);

  assign sys_inflight = |(valid_q & sys_q);
  assign cp0_stall    = sys_inflight & id_valid & (is_mfc0 | is_mtc0 | is_sys | is_eret);
  assign load         = id_valid & ~id_stall & ~cp0_stall & (is_mtc0 | is_sys);

  assign lookup_en = is_mfc0 | is_eret;
  assign lk_cs     = is_eret ? CS_W'(EPC_CS) : id_cs;
  assign lk_sel    = is_eret ? '0 : id_sel;

  always_comb begin
    valid_d = valid_q;
    sys_d   = sys_q;
    cs_d    = cs_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (!pipe_hold) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        sys_d[k]   = sys_q[k-1];
        cs_d[k]    = cs_q[k-1];
        sel_d[k]   = sel_q[k-1];
        data_d[k]  = data_q[k-1];
      end
      valid_d[0] = load;
      sys_d[0]   = load & is_sys;
      cs_d[0]    = id_cs;
      sel_d[0]   = id_sel;
      data_d[0]  = id_wdata;
    end
    // Flush acts on the positions entries occupy after this edge's shift.
    valid_d = valid_d & ~flush_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      sys_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sys_q   <= sys_d;
      cs_q    <= cs_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  // Scan oldest to youngest so the youngest hit overwrites older ones.
  always_comb begin
    fwd_src  = '0;
    fwd_data = rf_rdata;
    if (lookup_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid_q[DEPTH-1-i] && !sys_q[DEPTH-1-i] &&
            cs_q[DEPTH-1-i] == lk_cs && sel_q[DEPTH-1-i] == lk_sel) begin
          fwd_src  = SRC_W'(DEPTH - i);
          fwd_data = data_q[DEPTH-1-i];
        end
      end
    end
  end

`ifdef CP0_FWD_STATS_EN
  logic [31:0] fwd_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if ((fwd_src != '0) && id_valid && !pipe_hold && (fwd_cnt_q != '1))
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
      if (cp0_stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_fwd_cnt   = fwd_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cp0_fwd_tracker.sv
// Directed bench for cp0_fwd_tracker at DEPTH=2 and DEPTH=4; stats checks under CP0_FWD_STATS_EN.
module tb_cp0_fwd_tracker;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_MFC0 = 3'b001;
  localparam logic [2:0] OP_MTC0 = 3'b010;
  localparam logic [2:0] OP_SYS  = 3'b011;
  localparam logic [2:0] OP_ERET = 3'b100;
  localparam logic [31:0] RF = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst, pipe_hold, id_stall, id_valid;
  logic [1:0]  flush2;
  logic [3:0]  flush4;
  logic [2:0]  id_cp0_op;
  logic [4:0]  id_cs;
  logic [2:0]  id_sel;
  logic [31:0] id_wdata, rf_rdata;
  logic [31:0] data2, data4;
  logic [1:0]  src2;
  logic [2:0]  src4;
  logic        stall2, stall4, sys2, sys4;
`ifdef CP0_FWD_STATS_EN
  logic [31:0] fcnt2, scnt2, fcnt4, scnt4;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cp0_fwd_tracker #(.DATA_W(32), .DEPTH(2), .CS_W(5), .SEL_W(3), .EPC_CS(14)) u2 (
    .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .id_stall(id_stall),
    .flush_mask(flush2), .id_valid(id_valid), .id_cp0_op(id_cp0_op),
    .id_cs(id_cs), .id_sel(id_sel), .id_wdata(id_wdata), .rf_rdata(rf_rdata),
    .fwd_data(data2), .fwd_src(src2), .cp0_stall(stall2), .sys_inflight(sys2)
`ifdef CP0_FWD_STATS_EN
    , .stat_fwd_cnt(fcnt2), .stat_stall_cnt(scnt2)
`endif
  );

  cp0_fwd_tracker #(.DATA_W(32), .DEPTH(4), .CS_W(5), .SEL_W(3), .EPC_CS(14)) u4 (
    .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .id_stall(id_stall),
    .flush_mask(flush4), .id_valid(id_valid), .id_cp0_op(id_cp0_op),
    .id_cs(id_cs), .id_sel(id_sel), .id_wdata(id_wdata), .rf_rdata(rf_rdata),
    .fwd_data(data4), .fwd_src(src4), .cp0_stall(stall4), .sys_inflight(sys4)
`ifdef CP0_FWD_STATS_EN
    , .stat_fwd_cnt(fcnt4), .stat_stall_cnt(scnt4)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] cs,
                       input logic [2:0] sel, input logic [31:0] wd);
    id_valid  = v;
    id_cp0_op = op;
    id_cs     = cs;
    id_sel    = sel;
    id_wdata  = wd;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, OP_NONE, 5'd0, 3'd0, 32'd0);
    repeat (n) tick();
  endtask

  task automatic reset_pulse;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    #1;
  endtask

  int stall_cycles;

  initial begin
    rst = 1'b1; pipe_hold = 1'b0; id_stall = 1'b0; flush2 = '0; flush4 = '0;
    rf_rdata = RF;
    idle(2);
    rst = 1'b0;
    drive(1'b1, OP_ERET, 5'd0, 3'd0, 32'd0);
    check_val("rst_src", src2, 0);
    check_val("rst_data", data2, RF);
    check_val("rst_stall", stall2, 0);
    check_val("rst_sys", sys2, 0);
    idle(4);

    // MTC0 EPC then ERET back-to-back, then with one bubble
    drive(1'b1, OP_MTC0, 5'd14, 3'd0, 32'h0040_0100); tick();
    drive(1'b1, OP_ERET, 5'd0, 3'd0, 32'd0);
    check_val("eret_src1", src2, 1);
    check_val("eret_data1", data2, 32'h0040_0100);
    tick(); idle(4);
    drive(1'b1, OP_MTC0, 5'd14, 3'd0, 32'h0040_0100); tick();
    idle(1);
    drive(1'b1, OP_ERET, 5'd0, 3'd0, 32'd0);
    check_val("eret_src2", src2, 2);
    check_val("eret_data2", data2, 32'h0040_0100);
    tick(); idle(4);

    // youngest of two same-address writes wins
    drive(1'b1, OP_MTC0, 5'd14, 3'd0, 32'h100); tick();
    drive(1'b1, OP_MTC0, 5'd14, 3'd0, 32'h200); tick();
    drive(1'b1, OP_ERET, 5'd0, 3'd0, 32'd0);
    check_val("young_src", src2, 1);
    check_val("young_data", data2, 32'h200);
    tick(); idle(4);

    // select mismatch misses; matching select hits
    drive(1'b1, OP_MTC0, 5'd12, 3'd0, 32'h1);
    check_val("self_fwd_src", src2, 0);
    tick();
    drive(1'b1, OP_MFC0, 5'd12, 3'd1, 32'd0);
    check_val("sel_miss_src", src2, 0);
    check_val("sel_miss_data", data2, RF);
    drive(1'b1, OP_MFC0, 5'd12, 3'd0, 32'd0);
    check_val("sel_hit_src", src2, 1);
    check_val("sel_hit_data", data2, 32'h1);
    tick(); idle(4);

    // SYSCALL serialisation: plain drain
    drive(1'b1, OP_SYS, 5'd0, 3'd0, 32'd0); tick();
    drive(1'b1, OP_MFC0, 5'd14, 3'd0, 32'd0);
    check_val("sys_inflight", sys2, 1);
    stall_cycles = 0;
    for (int c = 0; c < 10; c++) begin
      if (!stall2) break;
      stall_cycles++;
      tick();
    end
    check_val("sys_stall_len", stall_cycles, 2);
    check_val("post_sys_src", src2, 0);
    check_val("post_sys_data", data2, RF);
    tick(); idle(4);

    // SYSCALL drain with a 3-cycle pipe_hold in the middle
    drive(1'b1, OP_SYS, 5'd0, 3'd0, 32'd0); tick();
    drive(1'b1, OP_MFC0, 5'd14, 3'd0, 32'd0);
    stall_cycles = 0;
    for (int c = 0; c < 12; c++) begin
      pipe_hold = (c >= 1 && c < 4);
      #1;
      if (!stall2) break;
      stall_cycles++;
      tick();
    end
    pipe_hold = 1'b0;
    check_val("hold_stall_len", stall_cycles, 5);
    tick(); idle(4);

`ifdef CP0_FWD_STATS_EN
    check_val("stat_fwd2", fcnt2, 32'd4);
    check_val("stat_stall2", scnt2, 32'd7);
`endif

    // flush of the freshly loaded entry
    flush2 = 2'b01;
    drive(1'b1, OP_MTC0, 5'd14, 3'd0, 32'h300); tick();
    flush2 = 2'b00;
    drive(1'b1, OP_ERET, 5'd0, 3'd0, 32'd0);
    check_val("flush_src", src2, 0);
    check_val("flush_data", data2, RF);
    tick(); idle(4);

    // id_stall: bubble enters entry 0 while older entry shifts
    drive(1'b1, OP_MTC0, 5'd14, 3'd0, 32'h700); tick();
    id_stall = 1'b1;
    drive(1'b1, OP_MTC0, 5'd14, 3'd0, 32'h800); tick();
    id_stall = 1'b0;
    drive(1'b1, OP_ERET, 5'd0, 3'd0, 32'd0);
    check_val("idstall_src", src2, 2);
    check_val("idstall_data", data2, 32'h700);
    tick(); idle(4);

    // pipe_hold dominates id_stall: nothing moves or loads
    drive(1'b1, OP_MTC0, 5'd14, 3'd0, 32'h500); tick();
    pipe_hold = 1'b1; id_stall = 1'b1;
    drive(1'b1, OP_MTC0, 5'd14, 3'd0, 32'h600); tick();
    pipe_hold = 1'b0; id_stall = 1'b0;
    drive(1'b1, OP_ERET, 5'd0, 3'd0, 32'd0);
    check_val("hold_src", src2, 1);
    check_val("hold_data", data2, 32'h500);
    tick(); idle(4);

    // reset mid-drain
    drive(1'b1, OP_MTC0, 5'd14, 3'd0, 32'hA); tick();
    drive(1'b1, OP_SYS, 5'd0, 3'd0, 32'd0); tick();
    drive(1'b1, OP_ERET, 5'd0, 3'd0, 32'd0);
    check_val("pre_rst_stall", stall2, 1);
    check_val("pre_rst_src", src2, 2);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    check_val("mid_rst_src", src2, 0);
    check_val("mid_rst_data", data2, RF);
    check_val("mid_rst_stall", stall2, 0);
    check_val("mid_rst_sys", sys2, 0);

    // DEPTH=4 chain: oldest entry reached through fwd_src=4
    reset_pulse();
    idle(4);
    drive(1'b1, OP_MTC0, 5'd1, 3'd0, 32'h11); tick();
    drive(1'b1, OP_MTC0, 5'd2, 3'd0, 32'h22); tick();
    drive(1'b1, OP_MTC0, 5'd3, 3'd0, 32'h33); tick();
    drive(1'b1, OP_MTC0, 5'd4, 3'd0, 32'h44); tick();
    drive(1'b1, OP_MFC0, 5'd1, 3'd0, 32'd0);
    check_val("d4_oldest_src", src4, 4);
    check_val("d4_oldest_data", data4, 32'h11);
    check_val("d4_u2_miss", src2, 0);
    tick();
    drive(1'b1, OP_MFC0, 5'd2, 3'd0, 32'd0);
    check_val("d4_next_src", src4, 4);
    check_val("d4_next_data", data4, 32'h22);
    tick();
    drive(1'b1, OP_MFC0, 5'd4, 3'd0, 32'd0);
    check_val("d4_mid_src", src4, 3);
    check_val("d4_mid_data", data4, 32'h44);
    pipe_hold = 1'b1;
    tick();
    pipe_hold = 1'b0;
    idle(5);
`ifdef CP0_FWD_STATS_EN
    check_val("stat_fwd4", fcnt4, 32'd2);
    check_val("stat_stall4", scnt4, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/cp0_fwd_tracker.md
Name: cp0_fwd_tracker

Overview:
- Parametrised successor to the fixed two-stage CP0 forwarding logic.
- Keeps a DEPTH-entry shift-register scoreboard of in-flight MTC0 writes and SYSCALLs between ID and CP0 commit.
- Resolves any ID-stage CP0 read (MFC0, or ERET's implicit EPC read) to the youngest in-flight value, or to the CP0 register file.
- Raises a serialisation stall while a SYSCALL is still in flight.

Parameters:
- DATA_W, 32, CP0 data width.
- DEPTH, 2, number of tracked stages after ID. Entry 0 is EX; entry DEPTH-1 is the last stage before CP0 commit.
- CS_W, 5, CP0 register number width.
- SEL_W, 3, CP0 select width.
- EPC_CS, 14, register number ERET reads, with sel 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_hold  in  1  whole pipeline frozen; no entry moves.
- id_stall  in  1  ID held; a bubble enters entry 0 and older entries still shift.
- flush_mask  in  DEPTH  bit k set clears entry k's valid this cycle.
- id_valid  in  1  ID holds a real instruction.
- id_cp0_op  in  3  001 MFC0, 010 MTC0, 011 SYSCALL, 100 ERET, others none.
- id_cs  in  CS_W  CP0 register (MFC0 read / MTC0 write).
- id_sel  in  SEL_W  CP0 select.
- id_wdata  in  DATA_W  MTC0 source data.
- rf_rdata  in  DATA_W  CP0 register-file read data for the ID lookup address.
- fwd_data  out  DATA_W  resolved CP0 read value.
- fwd_src  out  clog2(DEPTH+1)  0 = register file, k+1 = entry k.
- cp0_stall  out  1  ID must stall (serialisation).
- sys_inflight  out  1  any valid SYSCALL entry.

Behaviour:
- Entry fields: valid, is_sys, cs, sel, data.
- Reset clears every valid and is_sys. Outputs then read fwd_src=0, fwd_data=rf_rdata, cp0_stall=0, sys_inflight=0.
- Update, per rising edge, in priority order:
  - rst: clear all entries.
  - pipe_hold=1: entries keep their contents. flush_mask still clears the masked valids.
  - Otherwise:
    - entry[k] <= entry[k-1] for k ≥ 1.
    - Entry DEPTH-1 retires (discarded).
    - entry[0] is loaded when id_valid & !id_stall & !cp0_stall & op is MTC0 or SYSCALL:
      - MTC0: {cs, sel, data=id_wdata, is_sys=0}
      - SYSCALL: {is_sys=1, cs/sel/data don't-care}
    - Any other case loads a bubble (valid=0).
    - flush_mask is applied to the post-shift positions. A flushed entry is invalid next cycle.
- Lookup (combinational, zero latency):
  - Lookup address is (EPC_CS, 0) for ERET and (id_cs, id_sel) for MFC0.
  - A hit is an entry with valid & !is_sys & matching cs and sel.
  - The lowest-index (youngest) hit wins: fwd_src=k+1, fwd_data=entry[k].data.
  - No hit, or op not MFC0/ERET: fwd_src=0, fwd_data=rf_rdata.
  - A flush asserted this cycle does not affect this cycle's lookup. Entries cleared on the prior edge are not hits.
- Serialisation:
  - sys_inflight = OR over k of (valid[k] & is_sys[k]).
  - cp0_stall = sys_inflight & id_valid & (id_cp0_op in {001, 010, 011, 100}).
  - cp0_stall releases automatically because entries keep shifting while only ID is held.
- Boundaries:
  - Same address in several entries: the youngest wins.
  - MTC0 in ID does not forward to itself.
  - id_stall with pipe_hold: pipe_hold dominates and nothing moves.
  - DEPTH=1 is legal; fwd_src is then 1 bit wide.
  - Reset mid-drain drops all in-flight entries at once.

Optional Feature:
- Macro: CP0_FWD_STATS_EN.
- When defined, adds outputs stat_fwd_cnt[31:0] and stat_stall_cnt[31:0].
  - stat_fwd_cnt increments on cycles with fwd_src≠0 & id_valid & !pipe_hold.
  - stat_stall_cnt increments on cycles with cp0_stall=1.
  - Both counters saturate at 0xFFFFFFFF and are cleared by rst.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- DEPTH=2:
  - MTC0 cs=14 sel=0 data=0x0040_0100, then ERET next cycle -> fwd_src=1, fwd_data=0x0040_0100. With one bubble between them -> fwd_src=2.
  - MTC0 EPC=0x100, then MTC0 EPC=0x200, then ERET -> fwd_src=1, fwd_data=0x200.
  - MTC0 cs=12 data=0x1, then MFC0 cs=12 sel=1 -> fwd_src=0, fwd_data=rf_rdata.
  - SYSCALL captured, then MFC0 held in ID -> cp0_stall=1 for exactly 2 cycles, then fwd resolves normally. Repeat with pipe_hold=1 for 3 cycles mid-drain -> stall lasts 5 cycles.
- MTC0 EPC=0x300 in entry 0 with flush_mask=01 -> the following ERET sees fwd_src=0. rst mid-sequence -> all outputs at reset values next cycle.
- DEPTH=4: chain of 4 MTC0 to distinct registers, with MFC0 of the oldest -> fwd_src=4. Under CP0_FWD_STATS_EN, stat_fwd_cnt counts exactly the hit cycles.
